user_sprite_ctrl: RTL
=====================

# user_sprite_ctrl

- Pipelined sprite-fetch controller for the two player fish sprites.
- Latches each player's position, enable and facing at frame start.
- Maps every VGA pixel request to addresses for the four 3072-entry player sprite ROMs (player 1 and player 2, left and right facing).
- Composites the returned 4-bit palette indices with transparency and overlap priority. Sits between the VGA pixel counter and the colour mapper.

## Interface
Parameters:
- SPRITE_W, 64, sprite width in pixels
- SPRITE_H, 48, sprite height in pixels (SPRITE_W*SPRITE_H = 3072)
- ADDR_W, 19, ROM read-address width

Ports:
- Clk  in  1  system clock; single clock domain
- Reset  in  1  synchronous, active-high reset
- frame_start  in  1  one-cycle pulse at start of vertical blank
- p1_x, p1_y  in  10 each  player 1 top-left pixel coordinate
- p1_vx  in  10 signed  player 1 horizontal velocity
- p1_en  in  1  player 1 drawn
- p2_x, p2_y, p2_vx, p2_en  in  as player 1  player 2 equivalents
- pix_valid  in  1  DrawX/DrawY request valid this cycle
- DrawX, DrawY  in  10 each  requested pixel coordinate
- rom_addr_p1  out  ADDR_W  read address to both player 1 ROMs
- rom_addr_p2  out  ADDR_W  read address to both player 2 ROMs
- rom_u1l, rom_u1r, rom_u2l, rom_u2r  in  4 each  ROM data; 1-cycle registered latency
- pixel_valid  out  1  output pixel valid
- pixel_index  out  4  composited palette index; 0 = transparent/none
- pixel_owner  out  2  00 none, 01 player 1, 10 player 2

## Operation
Shadow registers, loaded on frame_start:
- Load x, y and en for each player.
- Facing per player: vx<0 sets left; vx>0 sets right; vx==0 holds.
- Pixels use only shadow values. No mid-frame tearing.

Stage 1 (per player):
- dx = DrawX − x and dy = DrawY − y, computed 11-bit signed.
- hit = en & 0≤dx<SPRITE_W & 0≤dy<SPRITE_H.
- Registered address = dy*SPRITE_W + dx, zero-extended to ADDR_W. Address is 0 when hit is 0.
- Hit, facing and valid are registered alongside the address.

Stage 2:
- ROM outputs arrive. hit, facing and valid are delayed one stage to stay aligned with the data.

Stage 3 (registered output):
- Each player's index is rom_u*l when facing left, else rom_u*r. The index is forced to 0 if that player's hit is 0.
- Opaque = index ≠ 0.
- If the top player is opaque, output it. Otherwise, if the other player is opaque, output it. Otherwise output index 0, owner 00.

Top player:
- top_p2 register; reset 0, so player 1 is on top.

Reset:
- All outputs 0, rom addresses 0.
- Pipeline valids cleared. Reset mid-line drops in-flight pixels.
- Shadows: positions 0, en 0, p1 facing right, p2 facing left.

## Timing
- Latency: pix_valid in cycle N gives pixel_valid in cycle N+3. Throughput is one pixel per cycle, with no stall or backpressure.
- rom_addr_p* are valid in cycle N+1. ROM data is consumed in cycle N+2.
- frame_start and pix_valid in the same cycle: that pixel uses the old shadows. New values apply from cycle N+1 requests.
- frame_start while pixels are in flight: in-flight pixels keep their stage-1 facing and hit.
- Boundary: dx=SPRITE_W−1 and dy=SPRITE_H−1 hit, giving address 3071. dx=SPRITE_W misses. Negative dx or dy (sprite partly off-screen left or top) misses without wrap.

## Configuration
PRIORITY_ROTATE_EN:
- Defined: top_p2 toggles on every frame_start, so overlap priority alternates each frame.
- Undefined: top_p2 is held at 0, and player 1 is always on top.

## Structure
- Package sprite_pkg: SPRITE_W, SPRITE_H, TRANSPARENT_IDX = 4'h0, owner enum (OWN_NONE, OWN_P1, OWN_P2), facing enum (FACE_RIGHT, FACE_LEFT).
- Sub-module user_sprite_hit: per-player stage-1 offset, range check and address; instantiated twice.

## Test plan
- Reset, then p1 at (100,50), en=1, vx=+1, frame_start. Request (100,50) → rom_addr_p1=0 at N+1; with rom_u1r=5, pixel_index=5, owner=01 at N+3.
- Request (163,97) with the same setup → address 3071, hit. Request (164,97) → owner 00, index 0.
- p1_vx=−2 then frame_start → rom_u1l selected. vx=0 then frame_start → stays left.
- p1 and p2 both at (200,200), request (210,210): p1 index 0, p2 index 7 → index 7, owner 10. p1 index 3 → index 3, owner 01.
- Same overlap with both opaque across two frames: with PRIORITY_ROTATE_EN, owner alternates 01, 10. Without it, owner stays 01.
- Stream 10 back-to-back pixels and assert Reset at the 5th → pixel_valid 0 from the next cycle, no stale outputs afterwards. p1_x changed mid-frame without frame_start → no effect.

Source files
------------

// File: rtl/sprite_pkg.sv
// sprite_pkg: shared constants, types and helpers for the player sprites.
// Imported by user_sprite_ctrl and user_sprite_hit.
package sprite_pkg;

  localparam int SPRITE_W = 64;
  localparam int SPRITE_H = 48;
  localparam logic [3:0] TRANSPARENT_IDX = 4'h0;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_P1   = 2'b01,
    OWN_P2   = 2'b10
  } owner_e;

  typedef enum logic {
    FACE_RIGHT = 1'b0,
    FACE_LEFT  = 1'b1
  } face_e;

  // Stationary players keep the direction they last moved in.
  function automatic face_e next_face(
    face_e             cur,
    logic signed [9:0] vx
  );
    if (vx[9]) return FACE_LEFT;
    if (vx != '0) return FACE_RIGHT;
    return cur;
  endfunction

  function automatic logic [3:0] pick_idx(
    logic       hit,
    face_e      f,
    logic [3:0] l,
    logic [3:0] r
  );
    if (!hit) return TRANSPARENT_IDX;
    return (f == FACE_LEFT) ? l : r;
  endfunction

endpackage

// File: rtl/user_sprite_hit.sv
// user_sprite_hit: per-player offset, range check and ROM address.
// Purely combinational; the caller registers the results.
module user_sprite_hit #(
  parameter int SPRITE_W = sprite_pkg::SPRITE_W,
  parameter int SPRITE_H = sprite_pkg::SPRITE_H,
  parameter int ADDR_W   = 19
) (
  input  logic [9:0]        draw_x,
  input  logic [9:0]        draw_y,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  input  logic              en,
  output logic              hit,
  output logic [ADDR_W-1:0] addr
);

  logic [10:0] dx;
  logic [10:0] dy;
  logic        in_x;
  logic        in_y;

  // 11-bit two's-complement offsets so left/top overhang is negative.
  assign dx = {1'b0, draw_x} - {1'b0, x};
  assign dy = {1'b0, draw_y} - {1'b0, y};

  assign in_x = ~dx[10] & (dx < 11'(SPRITE_W));
  assign in_y = ~dy[10] & (dy < 11'(SPRITE_H));
  assign hit  = en & in_x & in_y;

  assign addr = hit
    ? ADDR_W'(dy[9:0]) * ADDR_W'(SPRITE_W)
      + ADDR_W'(dx[9:0])
    : '0;

endmodule

// File: rtl/user_sprite_ctrl.sv
// user_sprite_ctrl: 3-stage fetch/composite for the two player sprites.
// Define PRIORITY_ROTATE_EN to alternate the top player every frame.
module user_sprite_ctrl #(
  parameter int SPRITE_W = sprite_pkg::SPRITE_W,
  parameter int SPRITE_H = sprite_pkg::SPRITE_H,
  parameter int ADDR_W   = 19
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_start,
  input  logic [9:0]        p1_x,
  input  logic [9:0]        p1_y,
  input  logic signed [9:0] p1_vx,
  input  logic              p1_en,
  input  logic [9:0]        p2_x,
  input  logic [9:0]        p2_y,
  input  logic signed [9:0] p2_vx,
  input  logic              p2_en,
  input  logic              pix_valid,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  output logic [ADDR_W-1:0] rom_addr_p1,
  output logic [ADDR_W-1:0] rom_addr_p2,
  input  logic [3:0]        rom_u1l,
  input  logic [3:0]        rom_u1r,
  input  logic [3:0]        rom_u2l,
  input  logic [3:0]        rom_u2r,
  output logic              pixel_valid,
  output logic [3:0]        pixel_index,
  output logic [1:0]        pixel_owner
);

  import sprite_pkg::*;

  logic [9:0] sh_x1, sh_y1, sh_x2, sh_y2;
  logic       sh_en1, sh_en2;
  face_e      sh_f1, sh_f2;
  logic       top_p2;

  logic              hit1, hit2;
  logic [ADDR_W-1:0] addr1, addr2;

  logic  s1_valid, s1_hit1, s1_hit2, s1_top;
  face_e s1_f1, s1_f2;
  logic  s2_valid, s2_hit1, s2_hit2, s2_top;
  face_e s2_f1, s2_f2;

  logic [3:0] idx1, idx2, idx_t, idx_b;
  owner_e     own_t, own_b;

  // Frame-start shadows; pixels never see the live player inputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sh_x1  <= '0;
      sh_y1  <= '0;
      sh_x2  <= '0;
      sh_y2  <= '0;
      sh_en1 <= 1'b0;
      sh_en2 <= 1'b0;
      sh_f1  <= FACE_RIGHT;
      sh_f2  <= FACE_LEFT;
      top_p2 <= 1'b0;
    end else if (frame_start) begin
      sh_x1  <= p1_x;
      sh_y1  <= p1_y;
      sh_x2  <= p2_x;
      sh_y2  <= p2_y;
      sh_en1 <= p1_en;
      sh_en2 <= p2_en;
      sh_f1  <= next_face(sh_f1, p1_vx);
      sh_f2  <= next_face(sh_f2, p2_vx);
`ifdef PRIORITY_ROTATE_EN
      top_p2 <= ~top_p2;
`else
      top_p2 <= 1'b0;
`endif
    end
  end

  user_sprite_hit #(
    .SPRITE_W(SPRITE_W),
    .SPRITE_H(SPRITE_H),
    .ADDR_W  (ADDR_W)
  ) u_hit1 (
    .draw_x(DrawX),
    .draw_y(DrawY),
    .x     (sh_x1),
    .y     (sh_y1),
    .en    (sh_en1),
    .hit   (hit1),
    .addr  (addr1)
  );

  user_sprite_hit #(
    .SPRITE_W(SPRITE_W),
    .SPRITE_H(SPRITE_H),
    .ADDR_W  (ADDR_W)
  ) u_hit2 (
    .draw_x(DrawX),
    .draw_y(DrawY),
    .x     (sh_x2),
    .y     (sh_y2),
    .en    (sh_en2),
    .hit   (hit2),
    .addr  (addr2)
  );

  // Stage 1: register ROM addresses with the context that travels along.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_valid    <= 1'b0;
      s1_hit1     <= 1'b0;
      s1_hit2     <= 1'b0;
      s1_f1       <= FACE_RIGHT;
      s1_f2       <= FACE_RIGHT;
      s1_top      <= 1'b0;
      rom_addr_p1 <= '0;
      rom_addr_p2 <= '0;
    end else begin
      s1_valid    <= pix_valid;
      s1_hit1     <= hit1;
      s1_hit2     <= hit2;
      s1_f1       <= sh_f1;
      s1_f2       <= sh_f2;
      s1_top      <= top_p2;
      rom_addr_p1 <= addr1;
      rom_addr_p2 <= addr2;
    end
  end

  // Stage 2: delay context to line up with the registered ROM data.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      s2_valid <= 1'b0;
      s2_hit1  <= 1'b0;
      s2_hit2  <= 1'b0;
      s2_f1    <= FACE_RIGHT;
      s2_f2    <= FACE_RIGHT;
      s2_top   <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      s2_hit1  <= s1_hit1;
      s2_hit2  <= s1_hit2;
      s2_f1    <= s1_f1;
      s2_f2    <= s1_f2;
      s2_top   <= s1_top;
    end
  end

  assign idx1 = pick_idx(s2_hit1, s2_f1, rom_u1l, rom_u1r);
  assign idx2 = pick_idx(s2_hit2, s2_f2, rom_u2l, rom_u2r);

  // Order the two candidates by the priority the pixel carried.
  always_comb begin
    idx_t = idx1;
    own_t = OWN_P1;
    idx_b = idx2;
    own_b = OWN_P2;
    if (s2_top) begin
      idx_t = idx2;
      own_t = OWN_P2;
      idx_b = idx1;
      own_b = OWN_P1;
    end
  end

  // Stage 3: first opaque candidate wins; idle cycles output nothing.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pixel_valid <= 1'b0;
      pixel_index <= TRANSPARENT_IDX;
      pixel_owner <= OWN_NONE;
    end else begin
      pixel_valid <= s2_valid;
      pixel_index <= TRANSPARENT_IDX;
      pixel_owner <= OWN_NONE;
      if (s2_valid && idx_t != TRANSPARENT_IDX) begin
        pixel_index <= idx_t;
        pixel_owner <= own_t;
      end else if (s2_valid && idx_b != TRANSPARENT_IDX) begin
        pixel_index <= idx_b;
        pixel_owner <= own_b;
      end
    end
  end

endmodule
